// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: binary-to-BCD double-dabble loader and 4-digit anode scan controller; optional leading-zero blanking via SSD_LEADING_ZERO_BLANK_EN
module ssd_scan_ctrl #(
  parameter int NUM_W        = 13,
  parameter int REFRESH_BITS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             num_valid,
  input  logic [NUM_W-1:0] num,
  output logic             num_ready,
  output logic             conv_done,
  output logic [3:0]       anode,
  output logic [3:0]       digit_bcd,
  output logic             digit_blank
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t                  state_q, state_d;
  logic [NUM_W-1:0]        bin_q, bin_d;
  logic [15:0]             bcd_q, bcd_d, adj, dig_q, dig_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]              sel, idx;
  // add-3 correction of every BCD nibble that would overflow on the next shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
  end
  // conversion FSM: capture, NUM_W shift steps, then one commit cycle
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    num_ready = (state_q == IDLE);
    conv_done = 1'b0;
    refresh_d = refresh_q + REFRESH_BITS'(1);
    case (state_q)
      IDLE: if (num_valid) begin
        bin_d   = (32'(num) > 32'd9999) ? NUM_W'(9999) : num;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[14:0], bin_q[NUM_W-1]};
        bin_d = {bin_q[NUM_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NUM_W-1)) state_d = COMMIT;
      end
      COMMIT: begin
        dig_d     = bcd_q;
        conv_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, shift registers, committed digits and free-running refresh counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      dig_q     <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      refresh_q <= refresh_d;
    end
  end
  // select 0 drives the thousands digit, so the nibble index is the inverted select
  assign sel       = refresh_q[REFRESH_BITS-1 -: 2];
  assign idx       = ~sel;
  assign anode     = ~(4'b1000 >> sel);
  assign digit_bcd = dig_q[{idx, 2'b00} +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [3:0] blank_q, blank_d;
  // blank a digit when it and all more-significant digits are zero; ones never blanks
  always_comb begin
    blank_d = blank_q;
    if (state_q == COMMIT) begin
      blank_d[3] = (bcd_q[15:12] == 4'd0);
      blank_d[2] = blank_d[3] && (bcd_q[11:8] == 4'd0);
      blank_d[1] = blank_d[2] && (bcd_q[7:4] == 4'd0);
      blank_d[0] = 1'b0;
    end
  end
  // blank mask updates together with the committed digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end
  assign digit_blank = blank_q[idx];
`else
  assign digit_blank = 1'b0;
`endif
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: random and directed loads checked every cycle against a decimal-arithmetic reference model
module tb_ssd_scan_ctrl;
  localparam int NUM_W = 13;
  localparam int RB    = 4;
  logic             clk = 0;
  logic             rst_n = 1;
  logic             num_valid = 0;
  logic [NUM_W-1:0] num = '0;
  logic             num_ready, conv_done, digit_blank;
  logic [3:0]       anode, digit_bcd;
  int n_chk = 0;
  int n_fail = 0;
  ssd_scan_ctrl #(.NUM_W(NUM_W), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .num_valid(num_valid), .num(num),
    .num_ready(num_ready), .conv_done(conv_done), .anode(anode),
    .digit_bcd(digit_bcd), .digit_blank(digit_blank)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  int m_ref = 0, m_busy = 0, m_cap = 0, m_disp = 0, m_com = 0;
  int pow10[4] = '{1000, 100, 10, 1};
  logic [3:0] an_tbl[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ref <= 0; m_busy <= 0; m_cap <= 0; m_disp <= 0; m_com <= 0;
    end else begin
      m_ref <= (m_ref + 1) % (1 << RB);
      if (m_busy == 0) begin
        if (num_valid) begin
          m_busy <= NUM_W + 1;
          m_cap  <= (int'(num) > 9999) ? 9999 : int'(num);
        end
      end else begin
        if (m_busy == 1) begin
          m_disp <= m_cap;
          m_com  <= 1;
        end
        m_busy <= m_busy - 1;
      end
    end
  end
  always @(negedge clk) begin
    int s;
    s = m_ref >> (RB - 2);
    check("num_ready", num_ready, m_busy == 0);
    check("conv_done", conv_done, m_busy == 1);
    check("anode", anode, an_tbl[s]);
    check("digit_bcd", digit_bcd, (m_disp / pow10[s]) % 10);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    check("digit_blank", digit_blank, m_com != 0 && s != 3 && m_disp < pow10[s]);
`else
    check("digit_blank", digit_blank, 0);
`endif
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input int v);
    num = NUM_W'(v);
    num_valid = 1;
    cyc(1);
    num_valid = 0;
  endtask
  initial begin
    #2 rst_n = 0;
    cyc(3);
    rst_n = 1;
    cyc(20);
    load(1234);
    cyc(40);
    num = 13'd8191;
    num_valid = 1;
    cyc(1);
    num = 13'd0;
    cyc(15);
    num_valid = 0;
    cyc(40);
    load(5000);
    cyc(4);
    load(7777);
    cyc(30);
    load(4321);
    cyc(5);
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc(20);
    load(42);
    cyc(40);
    load(0);
    cyc(40);
    load(7);
    cyc(40);
    for (int i = 0; i < 800; i++) begin
      num_valid = ($urandom % 3) == 0;
      num = NUM_W'($urandom_range(0, 8191));
      if ($urandom % 300 == 0) rst_n = 0;
      cyc(1);
      rst_n = 1;
    end
    num_valid = 0;
    cyc(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Display controller for the board's 4-digit seven-segment display. It accepts a binary value over a valid/ready handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It holds the committed digits and time-multiplexes them onto the anodes with a free-running refresh counter. A separate segment decoder downstream turns digit_bcd into segment patterns.

Parameters:
NUM_W, 13, width of the binary input; legal range 4..14.
REFRESH_BITS, 20, refresh counter width; the top 2 bits select the active digit. Simulation uses 4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
num_valid  input  1  num is valid this cycle.
num  input  NUM_W  binary value to display.
num_ready  output  1  controller can accept a value (high only in IDLE).
conv_done  output  1  one-cycle pulse when new digits are committed to the display.
anode  output  4  active-low digit enable; exactly one bit is low at any time.
digit_bcd  output  4  BCD value of the currently enabled digit.
digit_blank  output  1  current digit must be blanked (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async, rst_n=0) forces:
  - FSM=IDLE, refresh counter=0, committed digits all 0, shift registers 0.
  - num_ready=1, conv_done=0, anode=4'b0111, digit_bcd=0, digit_blank=0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - num_ready=1.
  - On num_valid && num_ready: capture num into the binary shift register, clear the BCD accumulator, clear the shift count, go to SHIFT.
  - num_valid while not ready is ignored; there is no queueing.
- SHIFT (exactly NUM_W cycles):
  - Each cycle, every BCD nibble >= 5 gets +3, then {bcd,bin} shifts left by 1.
  - After NUM_W shifts, go to COMMIT.
- COMMIT (1 cycle):
  - Copy the accumulator into the four committed digit registers atomically.
  - conv_done=1 for this cycle only; next state is IDLE.
- Latency:
  - Accept edge to conv_done high = NUM_W+1 cycles.
  - num_ready is low for NUM_W+1 cycles; back-to-back accepts are spaced NUM_W+2 cycles.
- Displayed digits change only in COMMIT and never show partial conversion results.
- Saturation: if the captured num > 9999, 9999 is loaded instead (unreachable for NUM_W <= 13; required for NUM_W=14).
- Scan:
  - The refresh counter increments every cycle and wraps modulo 2^REFRESH_BITS. It runs independently of the FSM.
  - Select = counter[REFRESH_BITS-1:REFRESH_BITS-2]:
    - 00: anode 0111, thousands
    - 01: anode 1011, hundreds
    - 10: anode 1101, tens
    - 11: anode 1110, ones
  - anode and digit_bcd are combinational from select and the committed digits.
- Reset asserted mid-SHIFT aborts the conversion: no conv_done, and the display shows 0000.
- num_valid asserted in the same cycle rst_n deasserts is ignored; the first accept can occur on the following edge.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined:
  - In COMMIT, compute a 4-bit blank mask: a digit is blanked if it and every more-significant digit are 0.
  - The ones digit is never blanked, so value 0 shows "   0".
  - digit_blank = mask bit of the selected digit; it is registered and updates with the digits.
- Undefined: digit_blank is constant 0, no mask logic is built, and all four digits always display.

Test Plan (REFRESH_BITS=4, NUM_W=13):
- Reset: hold rst_n=0 for 3 cycles -> anode=0111, digit_bcd=0, num_ready=1, conv_done=0; after release, anode steps 0111->1011->1101->1110 every 4 cycles.
- Load 1234: num_valid=1 for 1 cycle in IDLE -> num_ready=0 for 14 cycles, conv_done pulses on the 14th cycle after accept; scan then shows 1,2,3,4 on anodes 0111,1011,1101,1110.
- Load 8191 then 0 back-to-back: hold num_valid=1 continuously -> second accept exactly 15 cycles after the first; digits 8,1,9,1 then 0,0,0,0; the value presented while busy is not captured.
- Busy drop: load 5000, pulse num_valid with 7777 on cycle 5 of SHIFT -> 7777 ignored, display 5,0,0,0, exactly one conv_done.
- Reset mid-conversion: load 4321, assert rst_n=0 on SHIFT cycle 6 -> no conv_done, display 0000, num_ready=1 after release.
- With SSD_LEADING_ZERO_BLANK_EN: load 42 -> digit_blank=1 on anodes 0111 and 1011, 0 on 1101 (4) and 1110 (2); load 0 -> only the ones digit unblanked. Without the macro, digit_blank stays 0 throughout.
